jam_cost_server: RTL and testbench



---
 rtl/jam_cost_if.sv | 36 +++
 rtl/jam_cost_server.sv | 148 ++++++++++++++
 tb/tb_jam_cost_server.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_if.sv
// Cost-query bus between the system loader/JAM engine and jam_cost_server.
// Carries the matrix load stream, the engine's (W, J) -> Cost lookup, the
// engine reset and the engine result plus its captured copy.
// Ports: load_valid/load_ready/load_data, W/J/Cost, jam_rst,
//        Valid/MinCost/MatchCount, done/min_cost_q/match_count_q/timeout.
interface jam_cost_if #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
);
    logic              load_valid;
    logic              load_ready;
    logic [COST_W-1:0] load_data;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;
    logic              jam_rst;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              done;
    logic [9:0]        min_cost_q;
    logic [3:0]        match_count_q;
    logic              timeout;

    // Loader + engine side.
    modport master (
        output load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        input  load_ready, Cost, jam_rst, done, min_cost_q, match_count_q, timeout
    );

    // Cost server side.
    modport slave (
        input  load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        output load_ready, Cost, jam_rst, done, min_cost_q, match_count_q, timeout
    );
endinterface

// File: rtl/jam_cost_server.sv
// Purpose: holds the 2^IDX_W x 2^IDX_W cost matrix, serves JAM engine (W,J) lookups, captures its result.
// Latency: Cost is combinational (zero cycles); all other outputs are registered (one cycle).
// Backpressure: load_ready high only in LOAD; one word accepted per load_valid cycle, none after the last.
//
// Ports: CLK/RST (async, active-high) plus bus (jam_cost_if.slave):
//   load_valid/load_ready/load_data - row-major matrix load stream (W outer, J inner)
//   W/J -> Cost                     - lookup, zero when the engine is not running
//   jam_rst                         - holds the engine in reset until the matrix is loaded
//   Valid/MinCost/MatchCount        - engine result, captured once into min_cost_q/match_count_q
//   done/timeout                    - result captured / engine gave up
// Optional: define JAM_TIMEOUT_EN to bound the SERVE phase to TIMEOUT cycles.
module jam_cost_server #(
    parameter int COST_W  = 7,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    jam_cost_if.slave   bus
);
    localparam int AW    = 2 * IDX_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RELEASE,
        S_SERVE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [9:0]     min_q, min_d;
    logic [3:0]     match_q, match_d;
    logic           load_ready_q;
    logic           jam_rst_q;
    logic           done_q;
    logic           load_fire;

    logic [COST_W-1:0] mem [DEPTH];

`ifdef JAM_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);
    logic [15:0] tcnt_q, tcnt_d;
    logic        to_q, to_d;
`endif

    // load_ready is asserted for the whole LOAD state, so a load_valid seen in
    // LOAD is always a handshake.
    assign load_fire = (state_q == S_LOAD) && bus.load_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        min_d   = min_q;
        match_d = match_q;
`ifdef JAM_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == {AW{1'b1}}) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_SERVE;
`ifdef JAM_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            S_SERVE: begin
`ifdef JAM_TIMEOUT_EN
                tcnt_d = tcnt_q + 16'd1;
`endif
                // A result arriving on the expiry cycle takes priority.
                if (bus.Valid) begin
                    min_d   = bus.MinCost;
                    match_d = bus.MatchCount;
                    state_d = S_DONE;
                end
`ifdef JAM_TIMEOUT_EN
                else if (tcnt_d == TMO_LIM) begin
                    min_d   = 10'h3FF;
                    match_d = '0;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            default: ;  // S_DONE: left only through RST
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_LOAD;
            addr_q       <= '0;
            min_q        <= '0;
            match_q      <= '0;
            load_ready_q <= 1'b1;
            jam_rst_q    <= 1'b1;
            done_q       <= 1'b0;
`ifdef JAM_TIMEOUT_EN
            tcnt_q       <= '0;
            to_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            min_q        <= min_d;
            match_q      <= match_d;
            // Flags follow the next state so they are registered yet line up
            // with the state they describe.
            load_ready_q <= (state_d == S_LOAD);
            jam_rst_q    <= (state_d == S_LOAD) || (state_d == S_RELEASE);
            done_q       <= (state_d == S_DONE);
`ifdef JAM_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
            to_q         <= to_d;
`endif
        end
    end

    // Matrix storage carries no reset; a fresh load always rewrites every entry.
    always_ff @(posedge CLK) begin
        if (load_fire) begin
            mem[addr_q] <= bus.load_data;
        end
    end

    assign bus.Cost = ((state_q == S_SERVE) || (state_q == S_DONE)) ? mem[{bus.W, bus.J}] : '0;

    assign bus.load_ready    = load_ready_q;
    assign bus.jam_rst       = jam_rst_q;
    assign bus.done          = done_q;
    assign bus.min_cost_q    = min_q;
    assign bus.match_count_q = match_q;
`ifdef JAM_TIMEOUT_EN
    assign bus.timeout       = to_q;
`else
    assign bus.timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_jam_cost_server.sv
// Bench for jam_cost_server: loads the matrix under several patterns, reads it
// back through a scoreboard queue and checks result capture and reset behaviour.
module tb_jam_cost_server;
    localparam int COST_W = 7;
    localparam int IDX_W  = 3;
    localparam int TMO    = 100;

    logic CLK = 1'b0;
    logic RST;

    jam_cost_if #(.COST_W(COST_W), .IDX_W(IDX_W)) bus ();

    jam_cost_server #(.COST_W(COST_W), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int mc;
        int cnt;
    } res_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cost_q[$];
    res_t res_q[$];

    task automatic chk(input string tag, input int obs, input int expv);
        n_chk++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    endtask

    // Word stream patterns, indexed by row-major position idx = 8*W + J.
    function automatic int word(input int mode, input int idx);
        case (mode)
            0:       return idx;
            1:       return 63 - idx;
            2:       return 1;
            default: return 9;
        endcase
    endfunction

    // Streams words until load_ready drops or max_hs handshakes are done.
    // Returns at a negedge with load_valid (and Valid) deasserted.
    task automatic load_words(input int mode, input bit toggle, input bit pulse_valid,
                              input int max_hs, output int hs, output int cyc);
        hs  = 0;
        cyc = 0;
        forever begin
            @(negedge CLK);
            if (!bus.load_ready || hs >= max_hs || cyc >= 1000) break;
            bus.load_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.load_data  = 7'(word(mode, hs));
            bus.Valid      = pulse_valid && (cyc % 3 == 0);
            bus.MinCost    = 10'd77;
            bus.MatchCount = 4'd3;
            if (bus.load_valid) hs++;
            cyc++;
        end
        bus.load_valid = 1'b0;
        bus.Valid      = 1'b0;
    endtask

    task automatic read_cost(input int w, input int j, input int mode);
        @(negedge CLK);
        bus.W = 3'(w);
        bus.J = 3'(j);
        cost_q.push_back(word(mode, 8 * w + j));
        #1;
        chk($sformatf("cost(%0d,%0d)", w, j), int'(bus.Cost), cost_q.pop_front());
    endtask

    // One-cycle Valid pulse; returns at the following negedge.
    task automatic send_valid(input int mc, input int cnt);
        @(negedge CLK);
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'(mc);
        bus.MatchCount = 4'(cnt);
        @(negedge CLK);
        bus.Valid      = 1'b0;
    endtask

    task automatic check_result(input string tag);
        res_t r;
        r = res_q.pop_front();
        chk({tag, "_done"},  int'(bus.done), 1);
        chk({tag, "_min"},   int'(bus.min_cost_q), r.mc);
        chk({tag, "_match"}, int'(bus.match_count_q), r.cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, cyc, sum, n;
        RST            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.W          = '0;
        bus.J          = '0;
        bus.Valid      = 1'b0;
        bus.MinCost    = '0;
        bus.MatchCount = '0;
        repeat (2) @(negedge CLK);
        chk("rst_load_ready", int'(bus.load_ready), 1);
        chk("rst_jam_rst",    int'(bus.jam_rst), 1);
        chk("rst_done",       int'(bus.done), 0);
        chk("rst_cost",       int'(bus.Cost), 0);
        chk("rst_timeout",    int'(bus.timeout), 0);
        chk("rst_min",        int'(bus.min_cost_q), 0);
        chk("rst_match",      int'(bus.match_count_q), 0);
        RST = 1'b0;

        // Full load with load_valid held high.
        load_words(0, 1'b0, 1'b0, 1000, hs, cyc);
        chk("load_hs",        hs, 64);
        chk("load_cycles",    cyc, 64);
        chk("rel_load_ready", int'(bus.load_ready), 0);
        chk("rel_jam_rst",    int'(bus.jam_rst), 1);
        bus.W = 3'd3;
        bus.J = 3'd5;
        #1;
        chk("rel_cost", int'(bus.Cost), 0);
        @(negedge CLK);
        chk("serve_jam_rst",    int'(bus.jam_rst), 0);
        chk("serve_load_ready", int'(bus.load_ready), 0);
        read_cost(3, 5, 0);
        read_cost(7, 7, 0);
        read_cost(0, 0, 0);
        for (int i = 0; i < 6; i++) read_cost($urandom_range(0, 7), $urandom_range(0, 7), 0);
        chk("serve_done", int'(bus.done), 0);

        // Result capture, then a second result must be ignored.
        res_q.push_back('{300, 4});
        send_valid(300, 4);
        check_result("cap");
        chk("cap_timeout", int'(bus.timeout), 0);
        send_valid(10, 1);
        @(negedge CLK);
        chk("hold_min",     int'(bus.min_cost_q), 300);
        chk("hold_match",   int'(bus.match_count_q), 4);
        chk("hold_done",    int'(bus.done), 1);
        chk("hold_jam_rst", int'(bus.jam_rst), 0);
        read_cost(3, 5, 0);

        // Asynchronous reset mid-cycle while in DONE.
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_load_ready", int'(bus.load_ready), 1);
        chk("arst_jam_rst",    int'(bus.jam_rst), 1);
        chk("arst_done",       int'(bus.done), 0);
        chk("arst_cost",       int'(bus.Cost), 0);
        chk("arst_timeout",    int'(bus.timeout), 0);
        chk("arst_min",        int'(bus.min_cost_q), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Back-pressured load with Valid pulses during LOAD.
        load_words(1, 1'b1, 1'b1, 1000, hs, cyc);
        chk("bp_hs",     hs, 64);
        chk("bp_cycles", cyc, 127);
        chk("bp_done",   int'(bus.done), 0);
        @(negedge CLK);
        chk("bp_done_serve", int'(bus.done), 0);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) read_cost(w, j, 1);

        // Reset part way through a load, then a full reload of ones.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        load_words(3, 1'b0, 1'b0, 20, hs, cyc);
        chk("part_hs", hs, 20);
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        load_words(2, 1'b0, 1'b0, 1000, hs, cyc);
        chk("reload_hs",     hs, 64);
        chk("reload_cycles", cyc, 64);
        @(negedge CLK);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) read_cost(w, j, 2);
        // Minimal engine: identity assignment cost summed from the served matrix.
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            read_cost(i, i, 2);
            sum += int'(bus.Cost);
        end
        res_q.push_back('{8, 8});
        send_valid(sum, 8);
        check_result("eng");

`ifdef JAM_TIMEOUT_EN
        // Engine never reports: timeout after TMO SERVE cycles.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        load_words(0, 1'b0, 1'b0, 1000, hs, cyc);
        @(negedge CLK);
        chk("tmo_serve_jam_rst", int'(bus.jam_rst), 0);
        n = 0;
        while (!bus.done && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("tmo_cycles",  n, TMO);
        chk("tmo_flag",    int'(bus.timeout), 1);
        chk("tmo_min",     int'(bus.min_cost_q), 1023);
        chk("tmo_match",   int'(bus.match_count_q), 0);
`else
        n = 0;
        chk("no_tmo_flag", int'(bus.timeout) + n, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
